val2_shift_pipe: RTL and testbench

Pipelined, parametrised successor to the execute-stage Val2 generator. It produces the second ALU operand and the ARM shifter carry-out from the immediate, register-shift-by-immediate, register-shift-by-register and memory-offset encodings. A valid/ready handshake at each end lets the EX stage stall it, and a flush input kills in-flight operations on branch redirect.

---
 rtl/val2_shift_pipe_if.sv | 37 +++
 rtl/val2_shift_pipe.sv | 198 +++++++++++++++++++
 tb/tb_val2_shift_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/val2_shift_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : val2_shift_pipe_if
// Purpose  : Operand/handshake bundle between the EX stage and val2_shift_pipe.
// Revision : 1.0  initial release
// ============================================================================
interface val2_shift_pipe_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] val_rm;
    logic [7:0]        val_rs;
    logic [11:0]       shifter_operand;
    logic              imm;
    logic              mem_en;
    logic              reg_shift;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val2;
    logic              carry_out;

    modport master (
        output flush, in_valid, val_rm, val_rs, shifter_operand,
               imm, mem_en, reg_shift, carry_in, out_ready,
        input  in_ready, out_valid, val2, carry_out
    );

    modport slave (
        input  flush, in_valid, val_rm, val_rs, shifter_operand,
               imm, mem_en, reg_shift, carry_in, out_ready,
        output in_ready, out_valid, val2, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/val2_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : val2_shift_pipe
// Purpose  : Elastic pipelined Val2 / shifter-carry generator. Define
//            SHIFTER_RRX_EN to make register-form ROR #0 perform RRX.
// Revision : 1.0  initial release
// ============================================================================
module val2_shift_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    val2_shift_pipe_if.slave   bus
);
    localparam int         c_log2   = $clog2(DATA_W);
    localparam logic [7:0] c_width8 = 8'(DATA_W);
    localparam logic [1:0] c_lsl    = 2'd0;
    localparam logic [1:0] c_lsr    = 2'd1;
    localparam logic [1:0] c_asr    = 2'd2;

    logic [DATA_W-1:0] w_rm;
    logic              w_rm_msb;
    logic [7:0]        w_n;
    logic [c_log2-1:0] w_nl, w_idx_dn, w_idx_up, w_irot, w_irot_dn;
    logic [1:0]        w_type;

    assign w_rm      = bus.val_rm;
    assign w_rm_msb  = bus.val_rm[DATA_W-1];
    assign w_n       = bus.reg_shift ? bus.val_rs : {3'b000, bus.shifter_operand[11:7]};
    assign w_nl      = w_n[c_log2-1:0];
    assign w_type    = bus.shifter_operand[6:5];
    assign w_idx_dn  = w_nl - c_log2'(1);
    assign w_idx_up  = c_log2'(0) - w_nl;
    assign w_irot    = c_log2'({bus.shifter_operand[11:8], 1'b0});
    assign w_irot_dn = w_irot - c_log2'(1);

    // Every encoding is reduced to a right-rotate of a pre-masked source: bits
    // that the shift discards are cleared (or sign-filled) before rotating so
    // the pipelined barrel only ever rotates.
    logic [DATA_W-1:0] w_src, w_keep, w_dec_data;
    logic [c_log2-1:0] w_amt;
    logic              w_fill, w_carry;

    always_comb begin
        w_src   = w_rm;
        w_keep  = '1;
        w_fill  = 1'b0;
        w_amt   = '0;
        w_carry = bus.carry_in;
        if (bus.mem_en) begin
            w_src = DATA_W'(bus.shifter_operand);
        end else if (bus.imm) begin
            w_src = DATA_W'(bus.shifter_operand[7:0]);
            w_amt = w_irot;
            if (bus.shifter_operand[11:8] != 4'd0)
                w_carry = w_src[w_irot_dn];
        end else if (w_n == 8'd0) begin
            if (!bus.reg_shift) begin
                case (w_type)
                    c_lsr: begin
                        w_keep  = '0;
                        w_carry = w_rm_msb;
                    end
                    c_asr: begin
                        w_keep  = '0;
                        w_fill  = w_rm_msb;
                        w_carry = w_rm_msb;
                    end
                    default: begin
`ifdef SHIFTER_RRX_EN
                        if (w_type == 2'd3) begin
                            w_src   = {w_rm[DATA_W-1:1], bus.carry_in};
                            w_amt   = c_log2'(1);
                            w_carry = w_rm[0];
                        end
`endif
                    end
                endcase
            end
        end else begin
            case (w_type)
                c_lsl: begin
                    if (w_n < c_width8) begin
                        w_amt   = w_idx_up;
                        w_keep  = {DATA_W{1'b1}} >> w_nl;
                        w_carry = w_rm[w_idx_up];
                    end else begin
                        w_keep  = '0;
                        w_carry = (w_n == c_width8) ? w_rm[0] : 1'b0;
                    end
                end
                c_lsr: begin
                    if (w_n < c_width8) begin
                        w_amt   = w_nl;
                        w_keep  = {DATA_W{1'b1}} << w_nl;
                        w_carry = w_rm[w_idx_dn];
                    end else begin
                        w_keep  = '0;
                        w_carry = (w_n == c_width8) ? w_rm_msb : 1'b0;
                    end
                end
                c_asr: begin
                    w_fill = w_rm_msb;
                    if (w_n < c_width8) begin
                        w_amt   = w_nl;
                        w_keep  = {DATA_W{1'b1}} << w_nl;
                        w_carry = w_rm[w_idx_dn];
                    end else begin
                        w_keep  = '0;
                        w_carry = w_rm_msb;
                    end
                end
                default: begin
                    // A multiple of DATA_W wraps the index to the MSB.
                    w_amt   = w_nl;
                    w_carry = w_rm[w_idx_dn];
                end
            endcase
        end
    end

    assign w_dec_data = (w_src & w_keep) | ({DATA_W{w_fill}} & ~w_keep);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_lo    = s * c_log2 / STAGES;
        localparam int c_hi    = (s + 1) * c_log2 / STAGES;
        localparam int c_ain_w = c_log2 - c_lo;

        logic                           w_vin, w_cin, w_go;
        logic [DATA_W-1:0]              w_din;
        logic [c_ain_w-1:0]             w_ain;
        logic [c_hi-c_lo:0][DATA_W-1:0] w_chain;
        logic                           r_valid, r_carry;
        logic [DATA_W-1:0]              r_data;

        if (s == 0) begin : g_head
            assign w_vin = bus.in_valid;
            assign w_cin = w_carry;
            assign w_din = w_dec_data;
            assign w_ain = w_amt;
        end else begin : g_body
            assign w_vin = g_stage[s-1].r_valid;
            assign w_cin = g_stage[s-1].r_carry;
            assign w_din = g_stage[s-1].r_data;
            assign w_ain = g_stage[s-1].g_amt.r_amt;
        end

        if (s == STAGES - 1) begin : g_tail
            assign w_go = !r_valid || bus.out_ready;
        end else begin : g_mid
            assign w_go = !r_valid || g_stage[s+1].w_go;
        end

        assign w_chain[0] = w_din;
        for (genvar k = c_lo; k < c_hi; k++) begin : g_lvl
            localparam int c_sh = 1 << k;
            assign w_chain[k-c_lo+1] = w_ain[k-c_lo]
                ? ((w_chain[k-c_lo] >> c_sh) | (w_chain[k-c_lo] << (DATA_W - c_sh)))
                : w_chain[k-c_lo];
        end

        // Only the rotate bits not yet consumed travel on to later stages.
        if (s < STAGES - 1) begin : g_amt
            logic [c_log2-c_hi-1:0] r_amt;
            always_ff @(posedge clk) begin
                if (rst)
                    r_amt <= '0;
                else if (w_go && w_vin)
                    r_amt <= w_ain[c_ain_w-1:c_hi-c_lo];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_carry <= 1'b0;
            end else begin
                if (bus.flush)
                    r_valid <= 1'b0;
                else if (w_go)
                    r_valid <= w_vin;
                if (w_go && w_vin) begin
                    r_data  <= w_chain[c_hi-c_lo];
                    r_carry <= w_cin;
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].w_go;
    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.val2      = g_stage[STAGES-1].r_data;
    assign bus.carry_out = g_stage[STAGES-1].r_carry;

endmodule
`default_nettype wire

// File: tb/tb_val2_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_val2_shift_pipe
// Purpose  : Directed self-checking bench for val2_shift_pipe (DATA_W=32).
// Revision : 1.0  initial release
// ============================================================================
module tb_val2_shift_pipe;
    localparam int DATA_W = 32;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    val2_shift_pipe_if #(.DATA_W(DATA_W)) bus ();

    val2_shift_pipe #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [11:0] so, input logic [31:0] rm, input logic [7:0] rs,
                          input logic im, input logic me, input logic rsh, input logic ci);
        bus.shifter_operand = so;
        bus.val_rm          = rm;
        bus.val_rs          = rs;
        bus.imm             = im;
        bus.mem_en          = me;
        bus.reg_shift       = rsh;
        bus.carry_in        = ci;
    endtask

    task automatic run_op(input string tag, input logic [11:0] so, input logic [31:0] rm,
                          input logic [7:0] rs, input logic im, input logic me, input logic rsh,
                          input logic ci, input logic [31:0] ev, input logic ec);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_op(so, rm, rs, im, me, rsh, ci);
        bus.in_valid = 1'b1;
        #1;
        check({tag, "/rdy"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/lat"}, 64'(lat), 64'(STAGES));
        check({tag, "/val"}, 64'(bus.val2), 64'(ev));
        check({tag, "/c"}, 64'(bus.carry_out), 64'(ec));
    endtask

    // Two ops in flight under a stalled output, a third presented alongside
    // the kill (flush when use_rst=0, reset otherwise).
    task automatic kill_test(input string tag, input logic use_rst);
        int n_out;
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_op(12'h123, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        set_op(12'h456, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        set_op(12'h789, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check({tag, "/pre_ov"}, 64'(bus.out_valid), 64'd1);
        if (use_rst) rst = 1'b1;
        else         bus.flush = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        if (use_rst) begin
            #1;
            check({tag, "/rst_ov"}, 64'(bus.out_valid), 64'd0);
            check({tag, "/rst_val"}, 64'(bus.val2), 64'd0);
            check({tag, "/rst_c"}, 64'(bus.carry_out), 64'd0);
            rst = 1'b0;
        end
        #1;
        check({tag, "/ov"}, 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        n_out = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) n_out++;
        end
        check({tag, "/none_out"}, 64'(n_out), 64'd0);
        run_op({tag, "/next"}, 12'h040, 32'h8000_0010, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0,
               32'hF800_0001, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd;
        logic stalled_prev;
        logic [31:0] held_val;
        logic held_c;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_op(12'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("reset/ov", 64'(bus.out_valid), 64'd0);
        check("reset/val", 64'(bus.val2), 64'd0);
        check("reset/c", 64'(bus.carry_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset/in_ready", 64'(bus.in_ready), 64'd1);

        //     tag          so       Rm            Rs    im    mem   rsh   cin   val2          c
        run_op("imm_rot",   12'h4FF, 32'h0,        8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF00_0000, 1'b1);
        run_op("imm_rot0",  12'h0AB, 32'h0,        8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00AB, 1'b1);
        run_op("imm_rot2",  12'h1AB, 32'h0,        8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC000_002A, 1'b1);
        run_op("mem_pri1",  12'hABC, 32'hFFFF_FFFF, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0ABC, 1'b1);
        run_op("mem_pri0",  12'hABC, 32'hFFFF_FFFF, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 1'b0);
        run_op("rlsl32",    12'h000, 32'h8000_0001, 8'd32, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        run_op("rlsl33",    12'h000, 32'h8000_0001, 8'd33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        run_op("rlsl1",     12'h000, 32'h8000_0001, 8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b1);
        run_op("rasr200",   12'h040, 32'h8000_0001, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_op("rror32",    12'h060, 32'h8000_0001, 8'd32, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 1'b1);
        run_op("rror4",     12'h060, 32'h1234_5678, 8'd4,  1'b0, 1'b0, 1'b1, 1'b0, 32'h8123_4567, 1'b1);
        run_op("rlsr0",     12'h020, 32'h8000_0001, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 1'b0);
        run_op("rlsr32",    12'h020, 32'h8000_0001, 8'd32, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        run_op("ilsr0",     12'h020, 32'h8000_0001, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        run_op("iasr0",     12'h040, 32'h7FFF_FFFF, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        run_op("ilsl0",     12'h000, 32'h8000_0001, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 1'b0);
        run_op("ilsl4",     12'h200, 32'h1234_5678, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h2345_6780, 1'b1);
        run_op("ilsr8",     12'h420, 32'h1234_5678, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0012_3456, 1'b0);
        run_op("iasr4",     12'h240, 32'hF000_0008, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hFF00_0000, 1'b1);
`ifdef SHIFTER_RRX_EN
        run_op("iror0",     12'h060, 32'h8000_0001, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0000, 1'b1);
`else
        run_op("iror0",     12'h060, 32'h8000_0001, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 1'b1);
`endif

        // Back-pressure: six back-to-back ops, output stalled for cycles 3..7.
        sent = 0;
        rcvd = 0;
        stalled_prev = 1'b0;
        held_val = '0;
        held_c = 1'b0;
        for (int c = 0; c < 40 && rcvd < 6; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 7);
            bus.in_valid  = (sent < 6);
            set_op(12'(12'h100 + sent), 32'h0, 8'h0, 1'b0, 1'b1, 1'b0, sent[0]);
            #1;
            if (stalled_prev) begin
                check("bp/hold_ov", 64'(bus.out_valid), 64'd1);
                check("bp/hold_val", 64'(bus.val2), 64'(held_val));
                check("bp/hold_c", 64'(bus.carry_out), 64'(held_c));
            end
            check("bp/in_ready", 64'(bus.in_ready),
                  64'(((sent - rcvd) < STAGES) || bus.out_ready));
            stalled_prev = bus.out_valid && !bus.out_ready;
            held_val = bus.val2;
            held_c = bus.carry_out;
            if (bus.out_valid && bus.out_ready) begin
                check("bp/val", 64'(bus.val2), 64'(12'h100 + rcvd));
                check("bp/c", 64'(bus.carry_out), 64'(rcvd[0]));
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp/count", 64'(rcvd), 64'd6);

        kill_test("flush", 1'b0);
        kill_test("rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
